// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multi-cycle ARM datapath: shares one memory port and one ALU
// across FETCH/DECODE/execute phases and drives every datapath select and enable.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       op,
  input  logic [5:0]       funct,
  input  logic [3:0]       cond,
  input  logic [3:0]       NZCV,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             AdrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [3:0]       ALUOp,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic             Svalue,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXECR  = 4'd7,
    EXECI  = 4'd8,
    ALUWB  = 4'd9,
    BRANCH = 4'd10
  } state_t;

  state_t state, next_state;
  logic   cond_ex;
  logic   cond_true;
  logic   unused_flags;

  // Only Z participates in the supported condition codes.
  assign unused_flags = ^{NZCV[3], NZCV[1:0]};
  assign State        = state;

  always_comb begin
    unique case (cond)
      4'b0000: cond_true = NZCV[2];
      4'b0001: cond_true = ~NZCV[2];
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cond_ex    <= 1'b0;
      InstrCount <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE) cond_ex <= cond_true;
      if (next_state == FETCH && state != FETCH && state != IDLE)
        InstrCount <= InstrCount + 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case leaves a
    // signal unassigned and no latch is inferred.
    next_state = IDLE;
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUOp      = 4'b0000;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    Svalue     = 1'b0;

    if (state != IDLE) begin
      unique case (op)
        2'b01:   ImmSrc = 2'b01;
        2'b10: begin
          ImmSrc = 2'b10;
          RegSrc = 2'b01;
        end
        default: ;
      endcase
    end

    case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        MemReq     = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = 4'b0100;
        ResultSrc  = 2'b10;
        IRWrite    = MemReady;
        PCWrite    = MemReady;
        next_state = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        if (!cond_true) next_state = FETCH;
        else begin
          unique case (op)
            2'b01:   next_state = MEMADR;
            2'b00:   next_state = funct[5] ? EXECI : EXECR;
            2'b10:   next_state = BRANCH;
            default: next_state = FETCH;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        ALUOp      = funct[3] ? 4'b0100 : 4'b0010;
        next_state = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemReq     = 1'b1;
        AdrSrc     = 1'b1;
        next_state = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = cond_ex;
        next_state = FETCH;
      end
      MEMWR: begin
        MemReq     = 1'b1;
        MemWrite   = 1'b1;
        AdrSrc     = 1'b1;
        next_state = MemReady ? FETCH : MEMWR;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
        ALUOp      = funct[4:1];
        Svalue     = funct[0] & cond_ex;
        next_state = ALUWB;
      end
      ALUWB: begin
        RegWrite   = cond_ex & (funct[4:1] != 4'b1010);
        next_state = FETCH;
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ALUOp      = 4'b0100;
        ResultSrc  = 2'b10;
        PCWrite    = cond_ex;
        next_state = FETCH;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: an instruction-level model expands each instruction into the
// expected per-cycle control outputs, compared against the DUT with random stimulus.
module tb_multicycle_control_fsm;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       op;
  logic [5:0]       funct;
  logic [3:0]       cond, NZCV;
  logic             MemReady;
  logic             MemReq, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, ALUSrcA, Svalue;
  logic [1:0]       ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [3:0]       ALUOp, State;
  logic [CNT_W-1:0] InstrCount;

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .cond(cond), .NZCV(NZCV),
    .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .Svalue(Svalue), .State(State), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] state;
    logic       memreq, memwrite, irwrite, pcwrite, regwrite, adrsrc, alusrca;
    logic [1:0] alusrcb, resultsrc;
    logic [3:0] aluop;
    logic [1:0] immsrc, regsrc;
    logic       svalue;
  } obs_t;

  typedef struct {
    obs_t o;
    logic rdy;
    logic post_decode;
  } step_t;

  obs_t             got;
  step_t            exp_q[$];
  logic [CNT_W-1:0] cnt_exp;
  int               checks = 0;
  int               errors = 0;

  assign got = {State, MemReq, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ALUOp, ImmSrc, RegSrc, Svalue};

  task automatic check_obs(input string tag, input obs_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] exp);
    checks++;
    assert (InstrCount === exp) else begin
      errors++;
      $error("FAIL %s InstrCount observed=%0d expected=%0d", tag, InstrCount, exp);
    end
  endtask

  // Immediate/register-source selection depends only on the instruction class.
  function automatic obs_t base(input logic [3:0] st, input logic [1:0] o_op);
    obs_t o = '0;
    o.state = st;
    if (o_op == 2'b01) o.immsrc = 2'b01;
    if (o_op == 2'b10) begin
      o.immsrc = 2'b10;
      o.regsrc = 2'b01;
    end
    return o;
  endfunction

  task automatic push(input obs_t o, input logic rdy, input logic post);
    step_t s;
    s.o = o;
    s.rdy = rdy;
    s.post_decode = post;
    exp_q.push_back(s);
  endtask

  // Expand one instruction into its expected cycle sequence.
  task automatic build(input logic [1:0] i_op, input logic [5:0] i_funct,
                       input logic [3:0] i_cond, input logic z,
                       input int fetch_wait, input int mem_wait);
    obs_t o;
    logic taken;
    for (int w = 0; w <= fetch_wait; w++) begin
      o = base(4'd1, i_op);
      o.memreq = 1'b1; o.alusrca = 1'b1; o.alusrcb = 2'b10;
      o.aluop = 4'b0100; o.resultsrc = 2'b10;
      o.irwrite = (w == fetch_wait);
      o.pcwrite = (w == fetch_wait);
      push(o, w == fetch_wait, 1'b0);
    end
    push(base(4'd2, i_op), 1'($urandom), 1'b0);
    taken = (i_cond == 4'b1110) || (i_cond == 4'b0000 && z) || (i_cond == 4'b0001 && !z);
    if (!taken) return;
    case (i_op)
      2'b01: begin
        o = base(4'd3, i_op);
        o.alusrcb = 2'b01;
        o.aluop = i_funct[3] ? 4'b0100 : 4'b0010;
        push(o, 1'($urandom), 1'b1);
        for (int w = 0; w <= mem_wait; w++) begin
          o = base(i_funct[0] ? 4'd4 : 4'd6, i_op);
          o.memreq = 1'b1; o.adrsrc = 1'b1; o.memwrite = !i_funct[0];
          push(o, w == mem_wait, 1'b1);
        end
        if (i_funct[0]) begin
          o = base(4'd5, i_op);
          o.resultsrc = 2'b01; o.regwrite = 1'b1;
          push(o, 1'($urandom), 1'b1);
        end
      end
      2'b00: begin
        o = base(i_funct[5] ? 4'd8 : 4'd7, i_op);
        o.alusrcb = i_funct[5] ? 2'b01 : 2'b00;
        o.aluop = i_funct[4:1];
        o.svalue = i_funct[0];
        push(o, 1'($urandom), 1'b1);
        o = base(4'd9, i_op);
        o.regwrite = (i_funct[4:1] != 4'b1010);
        push(o, 1'($urandom), 1'b1);
      end
      2'b10: begin
        o = base(4'd10, i_op);
        o.alusrcb = 2'b01; o.aluop = 4'b0100; o.resultsrc = 2'b10; o.pcwrite = 1'b1;
        push(o, 1'($urandom), 1'b1);
      end
      default: ;
    endcase
  endtask

  // Called at a negedge in FETCH; returns at the negedge of the next FETCH.
  task automatic run(input string tag, input logic [1:0] i_op, input logic [5:0] i_funct,
                     input logic [3:0] i_cond, input logic [3:0] i_nzcv,
                     input int fetch_wait, input int mem_wait);
    step_t s;
    exp_q.delete();
    build(i_op, i_funct, i_cond, i_nzcv[2], fetch_wait, mem_wait);
    op = i_op; funct = i_funct; cond = i_cond; NZCV = i_nzcv;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      MemReady = s.rdy;
      if (s.post_decode) NZCV = 4'($urandom);
      #1;
      check_obs(tag, s.o);
      check_cnt(tag, cnt_exp);
      @(posedge clk);
      @(negedge clk);
    end
    cnt_exp = cnt_exp + 1'b1;
  endtask

  initial begin
    obs_t o;
    logic [3:0] rc;
    reset_n = 1'b0; op = '0; funct = '0; cond = '0; NZCV = '0; MemReady = 1'b0;
    cnt_exp = '0;
    #12;
    check_obs("reset", '0);
    check_cnt("reset", '0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_obs("idle", '0);
    @(posedge clk);
    @(negedge clk);

    run("add_reg", 2'b00, 6'b001000, 4'b1110, 4'b0000, 0, 0);
    check_cnt("add_count", 32'd1);
    run("ldr_wait", 2'b01, 6'b011001, 4'b1110, 4'b0000, 0, 3);
    run("str_down", 2'b01, 6'b010000, 4'b1110, 4'b0000, 1, 2);
    run("cmp_imm", 2'b00, 6'b110101, 4'b1110, 4'b0000, 0, 0);
    run("beq_z0", 2'b10, 6'b000000, 4'b0000, 4'b0000, 0, 0);
    run("beq_z1", 2'b10, 6'b000000, 4'b0000, 4'b0100, 0, 0);
    run("bne_z1", 2'b10, 6'b000000, 4'b0001, 4'b0100, 0, 0);
    run("op11", 2'b11, 6'b111111, 4'b1110, 4'b0000, 0, 0);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: rc = 4'b0000;
        1: rc = 4'b0001;
        2: rc = 4'b1110;
        default: rc = 4'($urandom);
      endcase
      run("random", 2'($urandom), 6'($urandom), rc, 4'($urandom),
          $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // STR stalled in MEMWR, then reset aborts it asynchronously.
    op = 2'b01; funct = 6'b010000; cond = 4'b1110; MemReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    MemReady = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    o = base(4'd6, 2'b01);
    o.memreq = 1'b1; o.memwrite = 1'b1; o.adrsrc = 1'b1;
    check_obs("memwr_stall", o);
    check_cnt("memwr_stall", cnt_exp);
    reset_n = 1'b0;
    #1;
    check_obs("reset_in_memwr", '0);
    check_cnt("reset_in_memwr", '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Moore-style sequencer that turns the ARM datapath into a multi-cycle machine: one shared memory port for instructions and data, and one ALU reused for PC+4, address and branch-target calculation. It sits beside the datapath in place of the single-cycle decoder and conditional logic. It takes op/funct/cond from the instruction register and NZCV from the flag register, handshakes with memory, and drives every datapath select and enable.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
op  in  2  instr[27:26], stable from DECODE onward
funct  in  6  instr[25:20]
cond  in  4  instr[31:28]
NZCV  in  4  flag register; Z = NZCV[2]
MemReady  in  1  memory completes current request this cycle
MemReq  out  1  memory request, held until MemReady
MemWrite  out  1  write qualifier for MemReq
IRWrite  out  1  load instruction register
PCWrite  out  1  load PC from Result
RegWrite  out  1  register-file write enable
AdrSrc  out  1  0 = PC, 1 = ALUOut register
ALUSrcA  out  1  0 = RD1, 1 = PC
ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
ResultSrc  out  2  00 = ALUOut, 01 = Data register, 10 = ALUResult
ALUOp  out  4  ALU function (0100 add, 0010 sub, 1010 cmp)
ImmSrc  out  2  00 imm8, 01 imm12, 10 imm24
RegSrc  out  2  00 normal, 01 read R15 for branch
Svalue  out  1  flag-write enable, one cycle
State  out  4  current state encoding, for debug
InstrCount  out  CNT_W  retired-instruction counter

Behaviour:
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXECR 7, EXECI 8, ALUWB 9, BRANCH 10. Codes 11–15 are unreachable; if reached, go to IDLE.
- Reset (async, reset_n low): State = IDLE, CondEx = 0, InstrCount = 0. In IDLE every output is 0. IDLE → FETCH unconditionally on the next clock. Reset mid-operation aborts immediately, including MemReq/MemWrite, and no write completes.
- Defaults: any output not listed for a state is 0. ImmSrc/RegSrc are combinational from op in every non-IDLE state: op 00 → 00/00; op 01 → 01/00; op 10 → 10/01; op 11 → 00/00.
- FETCH: MemReq = 1, AdrSrc = 0, ALUSrcA = 1, ALUSrcB = 10, ALUOp = 0100, ResultSrc = 10. IRWrite = PCWrite = MemReady. Stay until MemReady, then → DECODE.
- DECODE: register CondEx from cond: 0000 → Z, 0001 → ~Z, 1110 → 1, else 0.
  - Next state when cond is false: FETCH.
  - Next state when cond is true: op 01 → MEMADR; op 00 with funct[5] = 0 → EXECR; op 00 with funct[5] = 1 → EXECI; op 10 → BRANCH; op 11 → FETCH.
- MEMADR: ALUSrcA = 0, ALUSrcB = 01. ALUOp = 0100 if funct[3] else 0010. funct[0] = 1 → MEMRD, else → MEMWR.
- MEMRD: MemReq = 1, AdrSrc = 1. Wait for MemReady, then → MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, then → FETCH.
- MEMWR: MemReq = MemWrite = 1, AdrSrc = 1, held every cycle until MemReady, then → FETCH.
- EXECR / EXECI: ALUSrcA = 0; ALUSrcB = 00 (EXECR) or 01 (EXECI); ALUOp = funct[4:1]; Svalue = funct[0]. Then → ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = (funct[4:1] != 1010), then → FETCH.
- BRANCH: ALUSrcA = 0, ALUSrcB = 01, ALUOp = 0100, ResultSrc = 10, PCWrite = 1, then → FETCH.
- InstrCount increments by 1 on every transition into FETCH from a state other than IDLE. This includes skipped and op = 11 instructions. It wraps modulo 2^CNT_W.
- Latency with MemReady = 1 immediately:
  - Data-processing: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
  - Skipped instruction: 2 cycles.
  - Each memory state adds one cycle per cycle MemReady is low.
- NZCV changes after DECODE do not affect the current instruction, because CondEx is registered.

Test Plan:
- Hold reset_n low, then release → State = 0 and all outputs 0 during reset. First clock gives State = 1 with MemReq = 1.
- ADD reg: cond = 1110, op = 00, funct = 001000, MemReady = 1 → States 1, 2, 7, 9, 1. ALUOp = 0100 in EXECR, RegWrite = 1 in ALUWB, InstrCount = 1.
- LDR: op = 01, funct = 011001, MemReady low 3 cycles in MEMRD → MemReq stays 1 for 4 cycles. ALUOp = 0100 in MEMADR. MEMWB asserts RegWrite = 1 with ResultSrc = 01.
- STR down: funct = 010000 → MEMADR gives ALUOp = 0010. MemWrite held with MemReq until MemReady, then FETCH. RegWrite stays 0 throughout.
- CMP imm: funct = 110101 → EXECI has Svalue = 1 and ALUOp = 1010. ALUWB has RegWrite = 0.
- BEQ: with Z = 0, DECODE → FETCH with PCWrite never asserted and InstrCount incremented. With Z = 1, goes through BRANCH with PCWrite = 1 and RegSrc = 01.
- Reset asserted in MEMWR → MemWrite drops to 0 asynchronously. State = 0, InstrCount = 0.
